// File: rtl/uart_word_tx.sv
// uart_word_tx: 8N1 UART transmitter that sends either one byte or a
// whole 32-bit word (four back-to-back frames, least-significant byte first).
//
// Handshake: a request is taken on any clk edge where in_send_en=1 and
// out_ready=1. The payload is captured on that edge. Requests made while
// out_ready=0 are dropped: they are not queued and do not disturb the
// frame in flight.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_send_en,
    input  logic        in_send_word,
    input  logic [31:0] in_data,
    output logic        out_serial,
    output logic        out_ready,
    output logic        out_tx_active,
    output logic        out_tx_done,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [2:0]      bytes_left;
    logic [31:0]     shift_reg;
    logic [7:0]      cur_byte;
    logic            bit_end;

    // The byte currently on the wire always sits in the low 8 bits.
    assign cur_byte = shift_reg[7:0];
    assign bit_end  = (baud_cnt == BAUD_LAST);

    assign out_ready     = (state == IDLE);
    assign out_tx_active = !out_ready;
    assign dbg_state     = state;

    // Frame sequencer: state, baud/bit/byte counters and the registered TX line.
    // out_serial is loaded with the level of the *next* bit at each bit
    // boundary so the pin changes exactly on the boundary edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_serial  <= 1'b1;
            out_tx_done <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            bytes_left  <= '0;
            shift_reg   <= '0;
        end else begin
            out_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    out_serial <= 1'b1;
                    if (in_send_en) begin
                        shift_reg  <= in_data;
                        bytes_left <= in_send_word ? 3'd4 : 3'd1;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        out_serial <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        out_serial <= cur_byte[0];
                        state      <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            out_serial <= 1'b1;
                            state      <= STOP;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            out_serial <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bytes_left > 3'd1) begin
                            // Next byte starts straight after this stop bit.
                            bytes_left <= bytes_left - 3'd1;
                            shift_reg  <= shift_reg >> 8;
                            out_serial <= 1'b0;
                            state      <= START;
                        end else begin
                            out_serial  <= 1'b1;
                            out_tx_done <= 1'b1;
                            state       <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: begin
                    out_serial <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx with a short bit period. A receiver model
// decodes the TX line and compares each byte against a queue of expected
// bytes pushed when the request is accepted.
module tb_uart_word_tx;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_send_en = 1'b0;
    logic        in_send_word = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_serial;
    logic        out_ready;
    logic        out_tx_active;
    logic        out_tx_done;
    logic [1:0]  dbg_state;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int accept_cyc = 0;
    logic [7:0] exp_q[$];

    uart_word_tx #(.CLKS_PER_BIT(T)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_send_en    (in_send_en),
        .in_send_word  (in_send_word),
        .in_data       (in_data),
        .out_serial    (out_serial),
        .out_ready     (out_ready),
        .out_tx_active (out_tx_active),
        .out_tx_done   (out_tx_done),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- receiver model / scoreboard ----------------
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (out_serial === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == T / 2) begin
                check_eq("rx_start_bit", out_serial, 0);
            end else if ((rx_cnt % T == T / 2) && (rx_cnt < 9 * T)) begin
                rx_byte[rx_cnt / T - 1] = out_serial;
            end else if (rx_cnt == 9 * T + T / 2) begin
                check_eq("rx_stop_bit", out_serial, 1);
                if (exp_q.size() == 0)
                    check_eq("rx_unexpected_byte", {24'h0, rx_byte}, 32'hFFFF_FFFF);
                else
                    check_eq("rx_byte", rx_byte, exp_q.pop_front());
                rx_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives a request in the current cycle (call just after a negedge);
    // the accepting edge is the next posedge.
    task automatic drive_req(input logic [31:0] data, input logic word);
        check_eq("ready_at_req", out_ready, 1);
        in_send_en   = 1'b1;
        in_send_word = word;
        in_data      = data;
        accept_cyc   = cyc;
        exp_q.push_back(data[7:0]);
        if (word) begin
            exp_q.push_back(data[15:8]);
            exp_q.push_back(data[23:16]);
            exp_q.push_back(data[31:24]);
        end
        @(posedge clk);
        #1;
        in_send_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] data, input logic word);
        @(negedge clk);
        drive_req(data, word);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_tx_done === 1'b1) begin
                check_eq(tag, cyc - accept_cyc, exp_lat);
                check_eq("ready_on_done", out_ready, 1);
                check_eq("active_on_done", out_tx_active, 0);
                check_eq("line_on_done", out_serial, 1);
                return;
            end
        end
        check_eq({tag, "_timeout"}, 0, 1);
    endtask

    // Watches n cycles; the line must stay high with no done pulse.
    task automatic watch_quiet(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_tx_done !== 1'b0 || out_serial !== 1'b1 || out_ready !== 1'b1) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [9:0] frame;

        // 1. reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_serial", out_serial, 1);
        check_eq("rst_ready", out_ready, 1);
        check_eq("rst_active", out_tx_active, 0);
        check_eq("rst_done", out_tx_done, 0);
        check_eq("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        watch_quiet("idle_after_reset", 6);

        // 2. single byte A5: exact line waveform and done latency
        frame = {1'b1, 8'hA5, 1'b0};
        send(32'h0000_00A5, 1'b0);
        for (int k = 0; k < 10 * T; k++) begin
            @(negedge clk);
            check_eq($sformatf("a5_line_%0d", k), out_serial, frame[k / T]);
            if (k % T == 1) check_eq("a5_active", out_tx_active, 1);
        end
        wait_done("a5_done_lat", 10 * T + 1);

        // 3. word 12345678: four bytes decoded in order, no gaps
        watch_quiet("idle_gap_3", 3);
        send(32'h1234_5678, 1'b1);
        wait_done("word_done_lat", 40 * T + 1);
        check_eq("word_q_empty", exp_q.size(), 0);

        // 4. request while busy is ignored
        watch_quiet("idle_gap_4", 3);
        send(32'h0000_005A, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("busy_ready", out_ready, 0);
        in_send_en = 1'b1;
        in_data    = 32'h0000_00FF;
        @(posedge clk);
        #1;
        in_send_en = 1'b0;
        wait_done("busy_done_lat", 10 * T + 1);
        watch_quiet("busy_no_second_frame", 15 * T);
        check_eq("busy_q_empty", exp_q.size(), 0);

        // 5. reset during byte 2, data bit 3 of a word
        send(32'hA1B2_C3D4, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (cyc - accept_cyc >= 58) break;
            @(negedge clk);
        end
        check_eq("mid_state_data", dbg_state, 2);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("mid_rst_serial", out_serial, 1);
        check_eq("mid_rst_ready", out_ready, 1);
        check_eq("mid_rst_active", out_tx_active, 0);
        check_eq("mid_rst_done", out_tx_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        watch_quiet("no_done_after_abort", 12 * T);
        send(32'h0000_003C, 1'b0);
        wait_done("post_rst_done_lat", 10 * T + 1);

        // 6. new request on the done cycle: back-to-back frames
        watch_quiet("idle_gap_6", 3);
        send(32'h0000_0081, 1'b0);
        wait_done("b2b_first_done_lat", 10 * T + 1);
        drive_req(32'h0000_0096, 1'b0);
        @(negedge clk);
        check_eq("b2b_start_low", out_serial, 0);
        check_eq("b2b_busy", out_ready, 0);
        check_eq("b2b_done_cleared", out_tx_done, 0);
        wait_done("b2b_second_done_lat", 10 * T + 1);

        watch_quiet("final_idle", 2 * T);
        check_eq("final_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
